// File: rtl/purge_controller.sv
// Self-purging redundant adder controller: votes over the non-purged module outputs
// and permanently disables any module that disagrees with the vote MISS_LIMIT times in a row.
module purge_controller #(
    parameter int N          = 6,
    parameter int THR        = 4,
    parameter int MISS_LIMIT = 3,
    parameter int CNT_W      = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N-1:0]           i_mod_out,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic                   i_clear,
    output logic [N-1:0]           o_gated_out,
    output logic                   o_vote_out,
    output logic                   o_vote_vld,
    output logic [N-1:0]           o_purged,
    output logic                   o_fault_evt,
    output logic [$clog2(N+1)-1:0] o_active_cnt,
    output logic                   o_alarm
);

    localparam int PW = $clog2(N+1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PURGE = 2'd1,
        ST_FAIL  = 2'd2
    } state_t;

    function automatic logic [PW-1:0] popcount(input logic [N-1:0] vec);
        logic [PW-1:0] sum;
        sum = '0;
        for (int k = 0; k < N; k++) begin
            sum = sum + PW'(vec[k]);
        end
        return sum;
    endfunction

    state_t        r_state;
    logic [N-1:0]  r_purged;
    logic          r_vote;
    logic          r_vote_vld;
    logic          r_fault_evt;
    logic [PW-1:0] r_active_cnt;
    logic          r_alarm;

    logic [N-1:0]  w_gated;
    logic          w_accept;
    logic          w_vote;
    logic          w_compare;
    logic [N-1:0]  w_mismatch;
    logic [N-1:0]  w_hit;
    logic [N-1:0]  w_purged_next;
    logic [PW-1:0] w_active_next;

    assign w_gated       = i_mod_out & ~r_purged;
    assign o_in_ready    = (r_state != ST_PURGE);
    assign w_accept      = i_in_valid & o_in_ready;
    assign w_vote        = (popcount(w_gated) >= PW'(THR));
    // Disagreement tracking only happens in RUN; FAIL still votes but never purges.
    assign w_compare     = w_accept && (r_state == ST_RUN) && !i_clear;
    assign w_purged_next = r_purged | w_hit;
    assign w_active_next = popcount(~w_purged_next);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mod
            logic [CNT_W-1:0] r_cnt;

            assign w_mismatch[gi] = !r_purged[gi] && (i_mod_out[gi] != w_vote);
            // A module is purged on the mismatch that would bring its count to MISS_LIMIT.
            assign w_hit[gi]      = w_compare && w_mismatch[gi] &&
                                    (r_cnt >= CNT_W'(MISS_LIMIT - 1));

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt <= '0;
                end else if (i_clear) begin
                    r_cnt <= '0;
                end else if (w_compare && !r_purged[gi]) begin
                    if (w_hit[gi]) begin
                        r_cnt <= '0;
                    end else if (w_mismatch[gi]) begin
                        r_cnt <= (r_cnt == CNT_W'(MISS_LIMIT)) ? r_cnt : r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_RUN;
            r_purged     <= '0;
            r_vote       <= 1'b0;
            r_vote_vld   <= 1'b0;
            r_fault_evt  <= 1'b0;
            r_active_cnt <= PW'(N);
            r_alarm      <= 1'b0;
        end else begin
            r_vote_vld  <= w_accept & ~i_clear;
            r_fault_evt <= 1'b0;
            if (w_accept && !i_clear) begin
                r_vote <= w_vote;
            end
            if (i_clear) begin
                r_state      <= ST_RUN;
                r_purged     <= '0;
                r_active_cnt <= PW'(N);
                r_alarm      <= 1'b0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        // Purge results are made visible during the PURGE cycle itself.
                        if (|w_hit) begin
                            r_purged     <= w_purged_next;
                            r_active_cnt <= w_active_next;
                            r_fault_evt  <= 1'b1;
                            r_alarm      <= (w_active_next < PW'(THR));
                            r_state      <= ST_PURGE;
                        end
                    end
                    ST_PURGE: r_state <= r_alarm ? ST_FAIL : ST_RUN;
                    ST_FAIL:  r_state <= ST_FAIL;
                    default:  r_state <= ST_RUN;
                endcase
            end
        end
    end

    assign o_gated_out  = w_gated;
    assign o_vote_out   = r_vote;
    assign o_vote_vld   = r_vote_vld;
    assign o_purged     = r_purged;
    assign o_fault_evt  = r_fault_evt;
    assign o_active_cnt = r_active_cnt;
    assign o_alarm      = r_alarm;

endmodule

// File: doc/purge_controller.md
Name: purge_controller

Overview:
Sequencing and purge controller for the self-purging redundant adder. It samples the N raw module outputs and forms the majority vote internally over the non-purged modules. It tracks per-module consecutive disagreement with the vote and permanently disables (purges) any module that disagrees MISS_LIMIT times in a row. It sits between the N redundant full-adder copies and the downstream logic, and drives the gated module vector plus a registered voted result.

Parameters:
N, 6, number of redundant modules.
THR, 4, vote threshold: vote=1 when the number of ones among active modules is >= THR; must satisfy 1 <= THR <= N.
MISS_LIMIT, 3, consecutive mismatching samples that trigger a purge; must be >= 1.
CNT_W, 2, mismatch counter width; must hold MISS_LIMIT.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
mod_out  in  N  raw module outputs, bit i = module i.
in_valid  in  1  sample strobe for mod_out.
in_ready  out  1  controller accepts a sample when in_valid & in_ready.
clear  in  1  synchronous re-arm: un-purge all modules and zero all counters.
gated_out  out  N  combinational: mod_out & ~purged.
vote_out  out  1  registered vote of the last accepted sample.
vote_vld  out  1  one-cycle pulse, one cycle after acceptance.
purged  out  N  registered purge mask, 1 = module disabled.
fault_evt  out  1  one-cycle pulse in the cycle purged gains bits.
active_cnt  out  $clog2(N+1)  registered count of non-purged modules.
alarm  out  1  sticky: active_cnt < THR, so the system can no longer vote 1.

Behaviour:
- Reset (async, rst_n=0): state=RUN, purged=0, all counters=0, vote_out=0, vote_vld=0, fault_evt=0, active_cnt=N, alarm=0. in_ready=1 after reset releases.
- States: RUN, PURGE, FAIL. in_ready=1 in RUN and FAIL, 0 in PURGE. A sample presented while in_ready=0 is not taken; the source holds it.
- Accept in RUN or FAIL, cycle t:
  - v = (popcount(gated_out) >= THR).
  - At t+1: vote_out=v, vote_vld=1.
- Counter update (RUN only): for each non-purged module i:
  - if mod_out[i] != v, cnt[i] increments, saturating at MISS_LIMIT;
  - else cnt[i] clears to 0.
  - Counters of purged modules are held at 0.
- RUN -> PURGE: at acceptance, if any non-purged cnt[i] would reach MISS_LIMIT, latch pend[i]=1 for all such i. Simultaneous modules are purged together.
- In the PURGE cycle:
  - purged |= pend; fault_evt=1; active_cnt updated; counters of newly purged modules cleared.
  - Next state is FAIL if the new active_cnt < THR (alarm=1), else RUN.
  - PURGE lasts exactly 1 cycle.
- FAIL:
  - Samples are still accepted and voted over the gated modules.
  - No comparisons and no further purges; alarm holds.
  - Exited only by clear or reset.
- clear (sampled at clk, any state): next state RUN, purged=0, counters=0, pend=0, active_cnt=N, alarm=0, fault_evt=0.
  - clear has priority over an acceptance in the same cycle; that sample is dropped and vote_vld=0 next cycle.
- Purged modules contribute 0 to the vote. Vote width arithmetic uses the full popcount width, so there is no overflow.
- Reset asserted mid-burst or mid-PURGE: all state returns to reset values immediately; no fault_evt is emitted.
- MISS_LIMIT=1: a module is purged on its first disagreement.

Test Plan:
- Reset, then mod_out=6'b111111 accepted -> vote_out=1, vote_vld pulses at t+1, purged=0, active_cnt=6, alarm=0.
- Module 2 stuck at 0, others 1, 3 consecutive accepts -> next cycle: purged=6'b000100, fault_evt=1 for 1 cycle, in_ready=0 for that cycle, active_cnt=5, state RUN.
- Module 2 sequence mismatch, mismatch, match, mismatch, mismatch -> no purge, fault_evt never asserts.
- Modules 0 and 1 both mismatch 3 times -> single PURGE: purged=6'b000011, active_cnt=4. Then module 3 mismatches 3 times -> purged=6'b001011, active_cnt=3, alarm=1, FAIL. Further mismatches leave purged unchanged.
- clear asserted in a PURGE cycle together with in_valid -> next cycle purged=0, active_cnt=6, alarm=0, vote_vld=0, in_ready=1.
- rst_n dropped asynchronously after 2 mismatches of module 5 -> all outputs return to reset values at once. After release, 2 more mismatches cause no purge because the counter restarted.
